// File: rtl/ysyx_24090012_lsu.sv
// Load/store bus master for the memory stage: aligns byte/half/word accesses
// onto a word-wide valid/ready bus and extends load data on the way back.
module ysyx_24090012_lsu #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_wen,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wmask,
   output logic        bus_wen,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state_q, state_n;
   logic [CNT_W-1:0]   cnt_q, cnt_n, cnt_inc;
   logic [1:0]         off_q, off_n;
   logic [1:0]         size_q, size_n;
   logic               uns_q, uns_n;
   logic               wen_q, wen_n;

   logic               bus_valid_n, bus_wen_n;
   logic [31:0]        bus_addr_n, bus_wdata_n;
   logic [3:0]         bus_wmask_n;
   logic               resp_valid_n, resp_err_n;
   logic [31:0]        resp_rdata_n;

   logic               illegal_c;
   logic [3:0]         lane_mask_c;
   logic [31:0]        lane_data_c;
   logic [31:0]        shifted_c;
   logic [31:0]        load_ext_c;

   assign req_ready = (state_q == IDLE) && !rst;
   assign cnt_inc   = cnt_q + CNT_W'(1);

   // Request legality and store lane placement, from the live request.
   always_comb begin
      illegal_c   = 1'b0;
      lane_mask_c = 4'b1111;
      lane_data_c = req_wdata;
      case (req_size)
         2'd0: begin
            lane_mask_c = 4'b0001 << req_addr[1:0];
            lane_data_c = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            illegal_c   = req_addr[0];
            lane_mask_c = 4'b0011 << req_addr[1:0];
            lane_data_c = {2{req_wdata[15:0]}};
         end
         2'd2: illegal_c = (req_addr[1:0] != 2'b00);
         default: illegal_c = 1'b1;
      endcase
   end

   // Load data extraction from the latched offset/size/signedness.
   always_comb begin
      shifted_c  = bus_rdata >> {off_q, 3'b000};
      load_ext_c = shifted_c;
      case (size_q)
         2'd0: load_ext_c = uns_q ? {24'h0, shifted_c[7:0]}
                                  : {{24{shifted_c[7]}}, shifted_c[7:0]};
         2'd1: load_ext_c = uns_q ? {16'h0, shifted_c[15:0]}
                                  : {{16{shifted_c[15]}}, shifted_c[15:0]};
         default: load_ext_c = shifted_c;
      endcase
   end

   // Next-state and next-output logic; bus fields hold unless a request is accepted.
   always_comb begin
      state_n      = state_q;
      cnt_n        = cnt_q;
      off_n        = off_q;
      size_n       = size_q;
      uns_n        = uns_q;
      wen_n        = wen_q;
      bus_valid_n  = bus_valid;
      bus_wen_n    = bus_wen;
      bus_addr_n   = bus_addr;
      bus_wdata_n  = bus_wdata;
      bus_wmask_n  = bus_wmask;
      resp_valid_n = 1'b0;
      resp_err_n   = 1'b0;
      resp_rdata_n = 32'h0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               off_n  = req_addr[1:0];
               size_n = req_size;
               uns_n  = req_unsigned;
               wen_n  = req_wen;
               if (illegal_c) begin
                  state_n      = RESP;
                  resp_valid_n = 1'b1;
                  resp_err_n   = 1'b1;
               end else begin
                  state_n     = REQ;
                  cnt_n       = '0;
                  bus_valid_n = 1'b1;
                  bus_addr_n  = {req_addr[31:2], 2'b00};
                  bus_wen_n   = req_wen;
                  bus_wmask_n = req_wen ? lane_mask_c : 4'b0000;
                  bus_wdata_n = req_wen ? lane_data_c : 32'h0;
               end
            end
         end
         REQ: begin
            if (bus_ready) begin
               state_n      = RESP;
               bus_valid_n  = 1'b0;
               resp_valid_n = 1'b1;
               resp_rdata_n = wen_q ? 32'h0 : load_ext_c;
            end else if ((TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT))) begin
               state_n      = RESP;
               bus_valid_n  = 1'b0;
               resp_valid_n = 1'b1;
               resp_err_n   = 1'b1;
            end else begin
               cnt_n = cnt_inc;
            end
         end
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         off_q      <= 2'b00;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         wen_q      <= 1'b0;
         bus_valid  <= 1'b0;
         bus_wen    <= 1'b0;
         bus_addr   <= 32'h0;
         bus_wdata  <= 32'h0;
         bus_wmask  <= 4'b0000;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         off_q      <= off_n;
         size_q     <= size_n;
         uns_q      <= uns_n;
         wen_q      <= wen_n;
         bus_valid  <= bus_valid_n;
         bus_wen    <= bus_wen_n;
         bus_addr   <= bus_addr_n;
         bus_wdata  <= bus_wdata_n;
         bus_wmask  <= bus_wmask_n;
         resp_valid <= resp_valid_n;
         resp_err   <= resp_err_n;
         resp_rdata <= resp_rdata_n;
      end
   end

endmodule

// File: tb/tb_ysyx_24090012_lsu.sv
// Directed bench for ysyx_24090012_lsu; the bench plays the SRAM slave by hand.
module tb_ysyx_24090012_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_wen;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        bus_valid;
   logic        bus_ready;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wmask;
   logic        bus_wen;
   logic [31:0] bus_rdata;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ysyx_24090012_lsu #(.TIMEOUT(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_wen      (req_wen),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .bus_valid    (bus_valid),
      .bus_ready    (bus_ready),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_wmask    (bus_wmask),
      .bus_wen      (bus_wen),
      .bus_rdata    (bus_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request; 'waits' = REQ cycles with bus_ready low before the ready cycle.
   task automatic access(input string tag, input logic [31:0] addr, input logic wen,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] rd, input int waits, input logic exp_err,
                         input logic [31:0] exp_rdata, input logic [3:0] exp_mask,
                         input logic [31:0] exp_wdata);
      logic [31:0] exp_addr;
      exp_addr = {addr[31:2], 2'b00};
      check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_addr = addr; req_wen = wen; req_size = size;
      req_unsigned = uns; req_wdata = wdata;
      tick();
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      req_size = 2'($urandom); req_unsigned = 1'($urandom);
      if (exp_err) begin
         check({tag, ".err_resp_valid"}, 32'(resp_valid), 32'd1);
         check({tag, ".err_flag"}, 32'(resp_err), 32'd1);
         check({tag, ".err_rdata"}, resp_rdata, 32'h0);
         check({tag, ".err_bus_valid"}, 32'(bus_valid), 32'd0);
         tick();
         check({tag, ".err_after_valid"}, 32'(resp_valid), 32'd0);
         check({tag, ".err_after_bus"}, 32'(bus_valid), 32'd0);
      end else begin
         for (int i = 0; i < waits; i++) begin
            check({tag, ".bus_valid"}, 32'(bus_valid), 32'd1);
            check({tag, ".bus_addr"}, bus_addr, exp_addr);
            check({tag, ".bus_wmask"}, 32'(bus_wmask), 32'(exp_mask));
            check({tag, ".bus_wen"}, 32'(bus_wen), 32'(wen));
            if (wen) check({tag, ".bus_wdata"}, bus_wdata, exp_wdata);
            check({tag, ".early_resp"}, 32'(resp_valid), 32'd0);
            bus_ready = 1'b0; bus_rdata = $urandom;
            tick();
         end
         check({tag, ".bus_valid_rdy"}, 32'(bus_valid), 32'd1);
         bus_ready = 1'b1; bus_rdata = rd;
         tick();
         bus_ready = 1'b0; bus_rdata = $urandom;
         check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
         check({tag, ".resp_err"}, 32'(resp_err), 32'd0);
         check({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
         check({tag, ".resp_bus_low"}, 32'(bus_valid), 32'd0);
         tick();
         check({tag, ".resp_once"}, 32'(resp_valid), 32'd0);
         check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_wen = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_wdata = 32'h0; bus_ready = 1'b0; bus_rdata = 32'h0;
      tick();
      tick();
      check("rst.req_ready", 32'(req_ready), 32'd0);
      check("rst.bus_valid", 32'(bus_valid), 32'd0);
      check("rst.bus_wen", 32'(bus_wen), 32'd0);
      check("rst.bus_addr", bus_addr, 32'h0);
      check("rst.bus_wdata", bus_wdata, 32'h0);
      check("rst.bus_wmask", 32'(bus_wmask), 32'd0);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.resp_rdata", resp_rdata, 32'h0);
      check("rst.resp_err", 32'(resp_err), 32'd0);
      rst = 1'b0;
      #1;

      // tag, addr, wen, size, uns, wdata, bus_rdata, waits, err, rdata, wmask, wdata
      access("sw",      32'h8000_0004, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0,         1, 1'b0, 32'h0,         4'b1111, 32'hDEAD_BEEF);
      access("lw",      32'h8000_0004, 1'b0, 2'd2, 1'b0, 32'h0,         32'hDEAD_BEEF, 1, 1'b0, 32'hDEAD_BEEF, 4'b0000, 32'h0);
      access("sb3",     32'h8000_0003, 1'b1, 2'd0, 1'b0, 32'h1234_565A, 32'h0,         1, 1'b0, 32'h0,         4'b1000, 32'h5A5A_5A5A);
      access("lb3",     32'h8000_0003, 1'b0, 2'd0, 1'b0, 32'h0,         32'h8000_0000, 1, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0);
      access("lbu3",    32'h8000_0003, 1'b0, 2'd0, 1'b1, 32'h0,         32'h8000_0000, 1, 1'b0, 32'h0000_0080, 4'b0000, 32'h0);
      access("lh2",     32'h8000_0002, 1'b0, 2'd1, 1'b0, 32'h0,         32'h8001_7FFF, 1, 1'b0, 32'hFFFF_8001, 4'b0000, 32'h0);
      access("lh0",     32'h8000_0000, 1'b0, 2'd1, 1'b0, 32'h0,         32'h8001_7FFF, 1, 1'b0, 32'h0000_7FFF, 4'b0000, 32'h0);
      access("sh2",     32'h8000_0002, 1'b1, 2'd1, 1'b0, 32'hABCD_1234, 32'h0,         1, 1'b0, 32'h0,         4'b1100, 32'h1234_1234);
      access("lbu1",    32'h8000_0001, 1'b0, 2'd0, 1'b1, 32'h0,         32'h1122_3344, 1, 1'b0, 32'h0000_0033, 4'b0000, 32'h0);
      access("lb2",     32'h8000_0002, 1'b0, 2'd0, 1'b0, 32'h0,         32'h00F0_0000, 1, 1'b0, 32'hFFFF_FFF0, 4'b0000, 32'h0);
      access("lhu2",    32'h8000_0002, 1'b0, 2'd1, 1'b1, 32'h0,         32'h8001_7FFF, 1, 1'b0, 32'h0000_8001, 4'b0000, 32'h0);
      access("mis_h",   32'h8000_0001, 1'b0, 2'd1, 1'b0, 32'h0,         32'h0,         1, 1'b1, 32'h0,         4'b0000, 32'h0);
      access("mis_w",   32'h8000_0002, 1'b1, 2'd2, 1'b0, 32'h1111_1111, 32'h0,         1, 1'b1, 32'h0,         4'b0000, 32'h0);
      access("size3",   32'h8000_0000, 1'b0, 2'd3, 1'b0, 32'h0,         32'h0,         1, 1'b1, 32'h0,         4'b0000, 32'h0);
      access("wait5",   32'h8000_0008, 1'b0, 2'd2, 1'b0, 32'h0,         32'h0BAD_F00D, 5, 1'b0, 32'h0BAD_F00D, 4'b0000, 32'h0);
      access("sb0_w3",  32'h8000_0010, 1'b1, 2'd0, 1'b0, 32'h0000_00C3, 32'h0,         3, 1'b0, 32'h0,         4'b0001, 32'hC3C3_C3C3);

      // Watchdog: bus_ready never comes, error after 8 REQ cycles; late ready ignored.
      check("to.req_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_addr = 32'h8000_0010; req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("to.bus_valid", 32'(bus_valid), 32'd1);
         check("to.no_resp", 32'(resp_valid), 32'd0);
         tick();
      end
      check("to.resp_valid", 32'(resp_valid), 32'd1);
      check("to.resp_err", 32'(resp_err), 32'd1);
      check("to.resp_rdata", resp_rdata, 32'h0);
      check("to.bus_low", 32'(bus_valid), 32'd0);
      bus_ready = 1'b1; bus_rdata = 32'h5555_5555;
      tick();
      bus_ready = 1'b0;
      check("to.late_resp", 32'(resp_valid), 32'd0);
      check("to.late_bus", 32'(bus_valid), 32'd0);
      check("to.late_ready", 32'(req_ready), 32'd1);

      // Reset in REQ: request dropped, no response.
      req_valid = 1'b1; req_addr = 32'h8000_0020; req_wen = 1'b1; req_size = 2'd2; req_wdata = 32'h7777_7777;
      tick();
      req_valid = 1'b0;
      check("rq.bus_valid", 32'(bus_valid), 32'd1);
      rst = 1'b1; bus_ready = 1'b1;
      #1;
      check("rq.ready_in_rst", 32'(req_ready), 32'd0);
      tick();
      check("rq.bus_dropped", 32'(bus_valid), 32'd0);
      check("rq.no_resp", 32'(resp_valid), 32'd0);
      check("rq.ready_held", 32'(req_ready), 32'd0);
      rst = 1'b0; bus_ready = 1'b0;
      #1;
      check("rq.ready_after", 32'(req_ready), 32'd1);
      tick();
      check("rq.no_resp2", 32'(resp_valid), 32'd0);
      check("rq.bus_idle", 32'(bus_valid), 32'd0);

      access("post_rst", 32'h8000_0004, 1'b0, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 1, 1'b0, 32'hCAFE_F00D, 4'b0000, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
